// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: opcodes, funct3 encodings and the
// memory-stage state type.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus: req/ack handshake with word address, byte enables and
// lane-replicated write data. The memory stage is the master.
interface mem_access_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic for loads and stores: legality check, store byte enables
// and replicated write data, and load extraction with sign/zero extension.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        illegal
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Flag unsupported funct3 values and accesses that cross their natural alignment.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    illegal = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_B, F3_BU: illegal = 1'b0;
        F3_H, F3_HU: illegal = lane[0];
        F3_W:        illegal = |lane;
        default:     illegal = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_B:    illegal = 1'b0;
        F3_H:    illegal = lane[0];
        F3_W:    illegal = |lane;
        default: illegal = 1'b1;
      endcase
    end
  end

  // Store side: enable only the addressed lanes and replicate the data across the word.
  always_comb begin
    be    = 4'b1111;
    wdata = rs2;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

  // Load side: pick the addressed byte/half and extend it to 32 bits.
  always_comb begin
    case (lane)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_data = {24'd0, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_data = {16'd0, rd_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: passes ALU results through, runs loads/stores over the
// data-memory bus, aborts hung accesses, and emits a one-cycle writeback bundle.
module mem_access
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        req,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        valid_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  mem_access_if.master bus,
  output logic        stall_out,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_rd_write,
  output logic [31:0] wb_data,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t    state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    lat_funct3;
  logic [1:0]    lat_lane;
  logic [4:0]    lat_rd;
  logic          lat_rd_write;

  logic        is_load_in, is_store_in, is_mem_in;
  logic        in_access, timeout_hit;
  logic        accept_alu, accept_mem, reject, complete, abort;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load_data;
  logic        al_illegal;

  assign is_load_in  = (opcode_in == OPC_LOAD);
  assign is_store_in = (opcode_in == OPC_STORE);
  assign is_mem_in   = is_load_in | is_store_in;
  assign in_access   = (state == ACCESS);
  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // In IDLE the aligner checks the presented op; in ACCESS it formats read data for the latched op.
  lsu_align u_align (
    .funct3    (in_access ? lat_funct3 : funct3_in),
    .lane      (in_access ? lat_lane : result_in[1:0]),
    .is_load   (in_access ? !bus.dmem_we : is_load_in),
    .is_store  (in_access ? bus.dmem_we : is_store_in),
    .rs2       (rs2_value_in),
    .rdata     (bus.dmem_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load_data),
    .illegal   (al_illegal)
  );

  // State register.
  always_ff @(posedge req or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state: leave IDLE on an accepted legal access, return once it finishes or times out.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_mem) state_next = ACCESS;
      ACCESS:  if (complete || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decode and upstream stall; a held pipeline (stall_in) produces no events.
  always_comb begin
    accept_alu = 1'b0;
    accept_mem = 1'b0;
    reject     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        stall_out = valid_in && is_mem_in && !al_illegal;
        if (valid_in && !stall_in) begin
          if (!is_mem_in)     accept_alu = 1'b1;
          else if (al_illegal) reject    = 1'b1;
          else                accept_mem = 1'b1;
        end
      end
      ACCESS: begin
        complete  = !stall_in && bus.dmem_ack;
        abort     = !stall_in && !bus.dmem_ack && timeout_hit;
        stall_out = !(complete || abort);
      end
      default: ;
    endcase
  end

  // Timeout counter: counts unacknowledged ACCESS cycles, frozen while stall_in is high.
  always_ff @(posedge req or negedge reset_n) begin
    if (!reset_n)                              cnt <= '0;
    else if (!in_access || complete || abort)  cnt <= '0;
    else if (!stall_in)                        cnt <= cnt + 1'b1;
  end

  // Registered bus outputs, latched op fields and the writeback bundle.
  always_ff @(posedge req or negedge reset_n) begin
    if (!reset_n) begin
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_be    <= '0;
      lat_funct3     <= '0;
      lat_lane       <= '0;
      lat_rd         <= '0;
      lat_rd_write   <= 1'b0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_rd_write    <= 1'b0;
      wb_data        <= '0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else if (!stall_in) begin
      wb_valid       <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
      if (accept_alu) begin
        wb_valid    <= 1'b1;
        wb_rd       <= rd_in;
        wb_rd_write <= rd_write_in;
        wb_data     <= result_in;
      end
      if (reject) begin
        wb_valid       <= 1'b1;
        misaligned_out <= 1'b1;
        wb_rd          <= rd_in;
        wb_rd_write    <= 1'b0;
        wb_data        <= result_in;
      end
      if (accept_mem) begin
        bus.dmem_req   <= 1'b1;
        bus.dmem_we    <= is_store_in;
        bus.dmem_addr  <= {result_in[31:2], 2'b00};
        bus.dmem_wdata <= al_wdata;
        bus.dmem_be    <= al_be;
        lat_funct3     <= funct3_in;
        lat_lane       <= result_in[1:0];
        lat_rd         <= rd_in;
        lat_rd_write   <= rd_write_in;
      end
      if (complete) begin
        bus.dmem_req <= 1'b0;
        wb_valid     <= 1'b1;
        wb_rd        <= lat_rd;
        wb_rd_write  <= bus.dmem_we ? 1'b0 : lat_rd_write;
        if (!bus.dmem_we) wb_data <= al_load_data;
      end
      if (abort) begin
        bus.dmem_req <= 1'b0;
        wb_valid     <= 1'b1;
        bus_err_out  <= 1'b1;
        wb_rd        <= lat_rd;
        wb_rd_write  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the RV32I pipeline, directly downstream of the execute stage.
- Consumes the registered ALU result (address or plain result), store data, destination register and opcode/funct3.
- Performs loads/stores on the data-memory bus through a req/ack handshake, and formats load data (byte lanes, sign/zero extension).
- Presents a one-cycle writeback bundle and stalls upstream while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait for dmem_ack in ACCESS before aborting with bus_err_out.
- OPC_LOAD, 7'b0000011, load opcode; belongs in the shared package.
- OPC_STORE, 7'b0100011, store opcode; belongs in the shared package.

Ports:
- req  in  1  pipeline clock, rising edge active.
- reset_n  in  1  asynchronous active-low reset.
- stall_in  in  1  downstream hold; freezes all state and outputs.
- valid_in  in  1  an instruction is presented on the inputs this cycle.
- opcode_in  in  7  instruction opcode.
- funct3_in  in  3  access size and signedness.
- result_in  in  32  ALU result; for loads and stores this is the effective address.
- rs2_value_in  in  32  store data.
- rd_in  in  5  destination register.
- rd_write_in  in  1  instruction writes rd.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data; valid while dmem_ack = 1.
- dmem_ack  in  1  access complete.
- stall_out  out  1  hold the upstream stages.
- wb_valid  out  1  writeback bundle valid.
- wb_rd  out  5  writeback register.
- wb_rd_write  out  1  register-file write enable.
- wb_data  out  32  writeback data.
- misaligned_out  out  1  one-cycle pulse: misaligned or illegal-funct3 access.
- bus_err_out  out  1  one-cycle pulse: access timed out.

Behaviour:

Reset:
- All outputs reset to 0; state resets to IDLE; timeout counter resets to 0.
- Reset asserted mid-ACCESS drops dmem_req immediately. No writeback is produced.

FSM states:
- IDLE, ACCESS.

IDLE, no memory op:
- Condition: valid_in and !stall_in, with opcode neither load nor store.
- Next edge: wb_valid=1, wb_rd=rd_in, wb_rd_write=rd_write_in, wb_data=result_in.
- Latency 1. stall_out stays 0.

IDLE, load/store presented:
- Legality check, combinational:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Load funct3 must be one of 000, 001, 010, 100, 101.
  - Store funct3 must be one of 000, 001, 010.
- Illegal access:
  - No bus request.
  - Next edge: misaligned_out=1 and wb_valid=1 with wb_rd_write=0.
  - stall_out stays 0.
- Legal access:
  - stall_out=1 combinationally in that cycle.
  - Op fields are latched.
  - Next edge: enter ACCESS, with dmem_req=1 and the address, wdata, be and we outputs driven from the latched fields.

ACCESS:
- dmem_req and all dmem_* outputs held stable until dmem_ack.
- stall_out = !dmem_ack.
- On the edge where dmem_ack=1:
  - Load: wb_data = formatted read data; wb_rd_write = rd_write_in as latched.
  - Store: wb_rd_write=0.
  - wb_valid=1, dmem_req=0, return to IDLE.
- dmem_ack received while in IDLE is ignored.

Timeout:
- The counter increments on every ACCESS cycle without ack.
- When the count reaches TIMEOUT_CYCLES-1 without ack: bus_err_out=1 pulse, wb_valid=1, wb_rd_write=0, dmem_req=0, return to IDLE.
- stall_out=0 in that final cycle.

Load formatting (lane = addr[1:0]):
- LB: byte at lane, sign-extended.
- LBU: byte at lane, zero-extended.
- LH: half at addr[1], sign-extended.
- LHU: half at addr[1], zero-extended.
- LW: full word.

Store formatting:
- SB: be = 4'b0001 << lane; wdata = byte replicated x4.
- SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated x2.
- SW: be = 4'b1111; wdata = rs2.

Pulses and stall:
- wb_valid, misaligned_out and bus_err_out are single-cycle pulses; they clear the next cycle unless new work completes.
- stall_in=1 freezes state, the counter and every registered output; the timeout counter does not advance.
- A new valid_in arriving while in ACCESS is not accepted; upstream is held by stall_out.

Decomposition:
- Shared package rv_pkg:
  - OPC_LOAD and OPC_STORE.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The state enum mem_state_t {IDLE, ACCESS}.
- One sub-module, lsu_align: purely combinational. It computes dmem_be, dmem_wdata and formatted load data from funct3, addr[1:0], rs2 and rdata, and flags illegal accesses. Unit-tested separately.

Test Plan:
- ALU op pass-through: opcode 0110011, result_in=0x00000007, rd_in=5, rd_write_in=1 -> one cycle later wb_valid=1, wb_rd=5, wb_data=0x7; stall_out never asserted.
- LB with sign extension: addr 0x1003, ack after 3 cycles with rdata=0x80AABBCC -> dmem_addr=0x1000; stall_out high until the ack cycle; wb_data=0xFFFFFF80.
- SH at addr 0x2002, rs2=0x1234ABCD, ack in 1 cycle -> dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xABCDABCD; wb_rd_write=0.
- LW at addr 0x3001 -> no dmem_req; misaligned_out pulses one cycle; wb_rd_write=0.
- LW with ack never asserted -> after TIMEOUT_CYCLES cycles bus_err_out pulses, dmem_req=0, state returns to IDLE, stall_out=0.
- reset_n asserted low mid-ACCESS -> dmem_req=0 immediately; no wb_valid; the next LW after release completes normally.
